// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart_tx byte-engine arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_BUSY
    } uart_arb_state_t;

    localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx engine signals of the arbiter, bundled as one interface.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) ();
    // Requester handshake: a byte moves when req_valid[i] & req_ready[i] are high
    // in the same cycle; req_ready is a one-cycle, one-hot pulse.
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [IDX_W-1:0]   grant_id;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_ready;
    logic               tx_tick;
    logic               busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready, tx_tick,
        output req_ready, grant_id, tx_data, tx_start, busy
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready, tx_tick,
        input  req_ready, grant_id, tx_data, tx_start, busy
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any && req[j[IDX_W-1:0]]) begin
                any                  = 1'b1;
                grant[j[IDX_W-1:0]] = 1'b1;
                idx                  = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx engine; UART_TX_ARB_LOCK_EN enables whole-message grants.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_arbiter_if.slave bus,
    output uart_arb_state_t dbg_state
);

    uart_arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]       ptr;
    logic [N_REQ-1:0]       elig;
    logic [N_REQ-1:0]       pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       idx_inc;
    logic                   pick_any;
    logic                   accept;
    logic [UART_BYTE_W-1:0] sel_byte;

`ifdef UART_TX_ARB_LOCK_EN
    logic             lock;
    logic [IDX_W-1:0] owner;
    logic             sel_last;

    // While a message is open only its owner may be granted.
    assign elig = lock ? (bus.req_valid & (N_REQ'(1) << owner)) : bus.req_valid;
`else
    logic unused_req_last;

    assign elig            = bus.req_valid;
    assign unused_req_last = ^bus.req_last;
`endif

    uart_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (elig),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign idx_inc   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign bus.busy  = (state != ARB_IDLE);
    assign dbg_state = state;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_byte = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_comb begin
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_last = sel_last | (pick_gnt[i] & bus.req_last[i]);
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.tx_start  = 1'b0;
        accept        = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (bus.tx_ready && pick_any) begin
                    accept        = 1'b1;
                    bus.req_ready = pick_gnt;
                    state_nxt     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.tx_start = 1'b1;
                // Ready falls right after start, but the engine only latches on a tick.
                if (!bus.tx_ready && bus.tx_tick) begin
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus.tx_ready) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            bus.grant_id <= '0;
            bus.tx_data  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock         <= 1'b0;
            owner        <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus.tx_data  <= sel_byte;
                bus.grant_id <= pick_idx;
`ifdef UART_TX_ARB_LOCK_EN
                if (sel_last) begin
                    lock <= 1'b0;
                    ptr  <= idx_inc;
                end else begin
                    lock  <= 1'b1;
                    owner <= pick_idx;
                end
`else
                ptr <= idx_inc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx engine (tick every 4 clk).
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N_REQ   = 4;
    localparam int IDX_W   = 2;
    localparam int FRAME_T = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    uart_arb_state_t dbg_state;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .IDX_W(IDX_W)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: {grant_id, byte} in the order the engine must send them.
    logic [9:0] exp_q[$];
    logic [8:0] src_q[N_REQ][$];

    task automatic send(input int i, input logic [7:0] data, input logic last);
        src_q[i].push_back({last, data});
    endtask

    task automatic expect_frame(input int id, input logic [7:0] data);
        exp_q.push_back({2'(id), data});
    endtask

    // Behavioural uart_tx: ready drops the cycle after start; latches only on a tick.
    logic [1:0] tick_cnt   = '0;
    int         m_cnt      = 0;
    logic       start_d    = 1'b0;
    logic       force_busy = 1'b0;

    assign bus.tx_tick  = (tick_cnt == 2'd3);
    assign bus.tx_ready = (m_cnt == 0) && !start_d && !force_busy;

    always @(posedge clk) begin
        tick_cnt <= tick_cnt + 2'd1;
        start_d  <= (bus.tx_start === 1'b1);
        if (start_d && bus.tx_start !== 1'b1) begin
            check("start_held", 32'(m_cnt != 0), 32'd1);
        end
        if (m_cnt != 0) begin
            if (bus.tx_tick) m_cnt <= m_cnt - 1;
        end else if (bus.tx_tick && bus.tx_start === 1'b1) begin
            m_cnt <= FRAME_T;
            if (exp_q.size() == 0) begin
                check("extra_frame", 32'({bus.grant_id, bus.tx_data}), 32'h3ff);
            end else begin
                check("frame", 32'({bus.grant_id, bus.tx_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Requester driver: present queue heads, pop on accept.
    initial begin
        logic [N_REQ-1:0] acc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_ready & bus.req_valid;
            if (bus.req_ready != '0) begin
                check("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
                check("ready_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                bus.req_valid[i] = (src_q[i].size() != 0);
                if (src_q[i].size() != 0) begin
                    bus.req_data[8*i +: 8] = src_q[i][0][7:0];
                    bus.req_last[i]        = src_q[i][0][8];
                end else begin
                    bus.req_data[8*i +: 8] = $urandom_range(255, 0);
                    bus.req_last[i]        = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_done();
        logic done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && src_q[3].size() == 0 &&
                dbg_state == ARB_IDLE && m_cnt == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ARB_IDLE));
    endtask

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1 rst = 1'b0;

        // Single byte from requester 1: accept same cycle, start on the next.
        @(posedge clk); #1;
        send(1, 8'h55, 1'b1);
        expect_frame(1, 8'h55);
        @(negedge clk);
        check("single_ready", 32'(bus.req_ready), 32'b0010);
        check("single_start_pre", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        check("single_ready_drop", 32'(bus.req_ready), 32'd0);
        check("single_start", 32'(bus.tx_start), 32'd1);
        check("single_data", 32'(bus.tx_data), 32'h55);
        check("single_gid", 32'(bus.grant_id), 32'd1);
        check("single_busy", 32'(bus.busy), 32'd1);
        wait_done();

        // Fairness from ptr=0 with all four requesters valid.
        do_reset();
        send(0, 8'hA0, 1'b1); send(1, 8'hA1, 1'b1); send(2, 8'hA2, 1'b1);
        send(3, 8'hA3, 1'b1); send(0, 8'hA0, 1'b1);
        expect_frame(0, 8'hA0); expect_frame(1, 8'hA1); expect_frame(2, 8'hA2);
        expect_frame(3, 8'hA3); expect_frame(0, 8'hA0);
        wait_done();

        // Engine not ready: no grant until ready returns.
        @(posedge clk); #1;
        force_busy = 1'b1;
        send(0, 8'h77, 1'b1);
        expect_frame(0, 8'h77);
        repeat (12) begin
            @(negedge clk);
            check("hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1 force_busy = 1'b0;
        wait_done();

        // Reset while BUSY: outputs cleared, no grant until the engine is ready.
        @(posedge clk); #1;
        send(3, 8'h33, 1'b1);
        expect_frame(3, 8'h33);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dbg_state == ARB_BUSY) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach_busy", 32'(seen), 32'd1);
        send(2, 8'h5A, 1'b1);
        expect_frame(2, 8'h5A);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.tx_ready) break;
            check("midrst_no_grant", 32'(bus.req_ready), 32'd0);
        end
        wait_done();

        // Multi-byte message from requester 0 competing with requester 1.
        do_reset();
        send(0, 8'hC0, 1'b0); send(0, 8'hC1, 1'b0); send(0, 8'hC2, 1'b1);
        send(1, 8'hD0, 1'b1); send(1, 8'hD1, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
        expect_frame(0, 8'hC0); expect_frame(0, 8'hC1); expect_frame(0, 8'hC2);
        expect_frame(1, 8'hD0); expect_frame(1, 8'hD1);
`else
        expect_frame(0, 8'hC0); expect_frame(1, 8'hD0); expect_frame(0, 8'hC1);
        expect_frame(1, 8'hD1); expect_frame(0, 8'hC2);
`endif
        wait_done();
        check("exp_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
